// File: rtl/serie_paralelo_pkg.sv
// Shared definitions for both ends of the serial link:
// the default word width, the counter width helper and the FSM state encoding.
package serie_paralelo_pkg;

  localparam int WIDTH_DEF = 32;

  // A counter that must hold 0..width needs this many bits.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sp_state_e;

endpackage

// File: rtl/serie_a_paralelo_if.sv
// Serial-in / parallel-out bundle.
// The master drives the serial bits and the consumer ready.
// The slave (the receiver) returns the assembled word and its status.
interface serie_a_paralelo_if
  import serie_paralelo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             S_IN;
  logic             S_START;
  logic             P_READY;
  logic [WIDTH-1:0] P_OUT;
  logic             P_VALID;
  logic             BUSY;
  logic             OVERRUN;

  modport master (
    output S_IN, S_START, P_READY,
    input  P_OUT, P_VALID, BUSY, OVERRUN
  );

  modport slave (
    input  S_IN, S_START, P_READY,
    output P_OUT, P_VALID, BUSY, OVERRUN
  );

endinterface

// File: rtl/sp_bit_counter.sv
// Counts sampled bits within a word.
// The count wraps to 0 on the sample that completes the word.
// wrap_o flags that the next enabled sample is the last bit of the word.
module sp_bit_counter
  import serie_paralelo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      clr_i,
  input  logic                      en_i,
  output logic [cnt_w(WIDTH)-1:0]   cnt_o,
  output logic                      wrap_o
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_o  = cnt_q;

  // Next count: advance on each sample, wrapping after the last bit.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous clear.
  // NOTE: state registers use non-blocking assignments.
  // Every register then updates from values sampled before the edge.
  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serie_a_paralelo.sv
// Serial-to-parallel receiver.
// Samples S_IN whenever S_START=1 and assembles WIDTH bits into a word.
// The word is offered on P_OUT with a VALID/READY handshake.
// A word that completes before the previous one is accepted replaces it,
// and OVERRUN pulses for one cycle.
module serie_a_paralelo
  import serie_paralelo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               CLK,
  input logic               RESET,
  serie_a_paralelo_if.slave sp
);

  localparam int CNT_W = cnt_w(WIDTH);

  sp_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             overrun_q, overrun_d;

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             sample;
  logic             complete;

  sp_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk_i  (CLK),
    .clr_i  (RESET),
    .en_i   (sample),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  // The first sample opens a frame; the WIDTH-th sample closes it.
  // NOTE: every signal driven in an always_comb gets a default first.
  // Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sp.S_START)         state_d = ST_SHIFT;
      ST_SHIFT: if (sp.S_START && wrap) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  // A sample happens on every S_START cycle.
  // A word completes on the sample taken when the counter sits at WIDTH-1.
  always_comb begin
    sample   = sp.S_START;
    complete = 1'b0;
    if (state_q == ST_SHIFT) complete = sp.S_START && wrap;
  end

  // Shift path.
  // The first received bit ends up at the MSB or the LSB after WIDTH shifts.
  always_comb begin
    shift_d = shift_q;
    if (sample) begin
      if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], sp.S_IN};
      else           shift_d = {sp.S_IN, shift_q[WIDTH-1:1]};
    end
  end

  // Handshake.
  // Acceptance drops VALID.
  // A completing word reloads P_OUT and keeps VALID high.
  // OVERRUN flags a word that displaced an unaccepted one.
  always_comb begin
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    overrun_d = 1'b0;
    if (p_valid_q && sp.P_READY) p_valid_d = 1'b0;
    if (complete) begin
      p_out_d   = shift_d;
      p_valid_d = 1'b1;
      overrun_d = p_valid_q && !sp.P_READY;
    end
  end

  // Data and output registers; reset clears everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shift_q   <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sp.P_OUT   = p_out_q;
  assign sp.P_VALID = p_valid_q;
  assign sp.OVERRUN = overrun_q;
  assign sp.BUSY    = (cnt != '0);

endmodule

// File: tb/tb_serie_a_paralelo.sv
module tb_serie_a_paralelo;
  import serie_paralelo_pkg::*;

  localparam int W = 32;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic s_in    = 1'b0;
  logic s_start = 1'b0;
  logic p_ready = 1'b0;
  logic chk_en  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serie_a_paralelo_if #(.WIDTH(W)) if_msb ();
  serie_a_paralelo_if #(.WIDTH(W)) if_lsb ();

  assign if_msb.S_IN    = s_in;
  assign if_msb.S_START = s_start;
  assign if_msb.P_READY = p_ready;
  assign if_lsb.S_IN    = s_in;
  assign if_lsb.S_START = s_start;
  assign if_lsb.P_READY = p_ready;

  serie_a_paralelo #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .CLK   (clk),
    .RESET (rst),
    .sp    (if_msb.slave)
  );

  serie_a_paralelo #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .CLK   (clk),
    .RESET (rst),
    .sp    (if_lsb.slave)
  );

  // ---------------- reference model ----------------
  // Bits are accumulated arithmetically in two orders.
  // The handshake is modelled as one pending-word slot.
  typedef struct packed {
    int          n;
    logic [31:0] acc_msb;
    logic [31:0] acc_lsb;
    logic        valid;
    logic        over;
    logic [31:0] out_msb;
    logic [31:0] out_lsb;
  } model_t;

  model_t m = '0;

  function automatic model_t model_step(model_t c, logic r, logic st, logic b, logic rdy);
    model_t nx = c;
    if (r) return '0;
    nx.over = 1'b0;
    if (c.valid && rdy) nx.valid = 1'b0;
    if (st) begin
      nx.acc_msb = c.acc_msb * 32'd2 + {31'd0, b};
      nx.acc_lsb = c.acc_lsb + ({31'd0, b} << c.n);
      nx.n       = c.n + 1;
      if (nx.n == W) begin
        nx.out_msb = nx.acc_msb;
        nx.out_lsb = nx.acc_lsb;
        nx.over    = c.valid && !rdy;
        nx.valid   = 1'b1;
        nx.n       = 0;
        nx.acc_msb = '0;
        nx.acc_lsb = '0;
      end
    end
    return nx;
  endfunction

  always @(posedge clk) m <= model_step(m, rst, s_start, s_in, p_ready);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both receivers against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid_msb", {31'd0, if_msb.P_VALID}, {31'd0, m.valid});
      check("cyc_valid_lsb", {31'd0, if_lsb.P_VALID}, {31'd0, m.valid});
      check("cyc_busy_msb", {31'd0, if_msb.BUSY}, {31'd0, m.n != 0});
      check("cyc_busy_lsb", {31'd0, if_lsb.BUSY}, {31'd0, m.n != 0});
      check("cyc_overrun_msb", {31'd0, if_msb.OVERRUN}, {31'd0, m.over});
      check("cyc_overrun_lsb", {31'd0, if_lsb.OVERRUN}, {31'd0, m.over});
      check("cyc_out_msb", if_msb.P_OUT, m.out_msb);
      check("cyc_out_lsb", if_lsb.P_OUT, m.out_lsb);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_bit(input logic b);
    @(negedge clk);
    s_start = 1'b1;
    s_in    = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, if_msb.P_VALID | if_lsb.P_VALID}, 32'd0);
    check({tag, "_busy"}, {31'd0, if_msb.BUSY | if_lsb.BUSY}, 32'd0);
    check({tag, "_overrun"}, {31'd0, if_msb.OVERRUN | if_lsb.OVERRUN}, 32'd0);
    check({tag, "_out_msb"}, if_msb.P_OUT, 32'd0);
    check({tag, "_out_lsb"}, if_lsb.P_OUT, 32'd0);
  endtask

  // Sends one word MSB-first, with optional gaps after two bit positions.
  // Returns the number of cycles from the first bit until P_VALID is seen.
  task automatic send_word(input logic [31:0] word, input int ga, input int gb,
                           input int gl, output int lat);
    lat = -1;
    for (int i = 0; i < W; i++) begin
      drive_bit(word[31-i]);
      lat++;
      if (i == ga || i == gb) begin
        for (int g = 0; g < gl; g++) begin
          @(negedge clk);
          s_start = 1'b0;
          s_in    = 1'($urandom);
          lat++;
          check("gap_busy", {31'd0, if_msb.BUSY & if_lsb.BUSY}, 32'd1);
        end
      end
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      s_start = 1'b0;
      lat++;
      if (if_msb.P_VALID) break;
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          ga;
    int          gb;
    int          gl;
    int          exp_lat;
    logic [31:0] exp_msb;
    logic [31:0] exp_lsb;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int pulses;
    int pos[2];
    logic [31:0] val_m[2];
    logic [31:0] val_l[2];
    int ovr;
    logic [31:0] w2;

    vecs[0] = '{32'hA5C3_0F81, -1, -1, 0, 32, 32'hA5C3_0F81, 32'h81F0_C3A5};
    vecs[1] = '{32'hA5C3_0F81,  7, 20, 3, 38, 32'hA5C3_0F81, 32'h81F0_C3A5};
    vecs[2] = '{32'h0000_0001, -1, -1, 0, 32, 32'h0000_0001, 32'h8000_0000};
    vecs[3] = '{32'hDEAD_BEEF,  0, 30, 1, 34, 32'hDEAD_BEEF, 32'hF77D_B57B};
    vecs[4] = '{32'h1234_5678, 15, -1, 2, 34, 32'h1234_5678, 32'h1E6A_2C48};

    // Reset held two cycles while serial activity is present.
    rst = 1'b1; s_start = 1'b1; s_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all_zero("reset");
      s_in = ~s_in;
    end
    rst = 1'b0; s_start = 1'b0;
    chk_en = 1'b1;

    // Table-driven single words, consumer always ready.
    p_ready = 1'b1;
    foreach (vecs[v]) begin
      send_word(vecs[v].word, vecs[v].ga, vecs[v].gb, vecs[v].gl, lat);
      check("vec_latency", lat, vecs[v].exp_lat);
      check("vec_out_msb", if_msb.P_OUT, vecs[v].exp_msb);
      check("vec_out_lsb", if_lsb.P_OUT, vecs[v].exp_lsb);
      @(negedge clk);
      check("vec_valid_pulse", {31'd0, if_msb.P_VALID}, 32'd0);
    end

    // Back-to-back: 64 continuous bits, two pulses 32 cycles apart.
    pulses = 0; ovr = 0;
    pos[0] = -1; pos[1] = -1;
    w2 = 32'h1234_5678;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      if (if_msb.OVERRUN) ovr++;
      if (if_msb.P_VALID) begin
        if (pulses < 2) begin
          pos[pulses] = k; val_m[pulses] = if_msb.P_OUT; val_l[pulses] = if_lsb.P_OUT;
        end
        pulses++;
      end
      if (k < 32)      begin s_start = 1'b1; s_in = 32'hDEAD_BEEF >> (31 - k); end
      else if (k < 64) begin s_start = 1'b1; s_in = w2[63-k]; end
      else             s_start = 1'b0;
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_pos0", pos[0], 32);
    check("b2b_pos1", pos[1], 64);
    check("b2b_word0_msb", val_m[0], 32'hDEAD_BEEF);
    check("b2b_word1_msb", val_m[1], 32'h1234_5678);
    check("b2b_word1_lsb", val_l[1], 32'h1E6A_2C48);
    check("b2b_overrun", ovr, 0);
    @(negedge clk);

    // Overrun: consumer stalled across two words, then releases.
    p_ready = 1'b0; ovr = 0;
    for (int k = 0; k <= 66; k++) begin
      @(negedge clk);
      if (if_msb.OVERRUN) ovr++;
      if (k == 32) begin
        check("ovr_first_valid", {31'd0, if_msb.P_VALID}, 32'd1);
        check("ovr_first_out", if_msb.P_OUT, 32'h0000_0001);
        check("ovr_first_flag", {31'd0, if_msb.OVERRUN}, 32'd0);
      end
      if (k == 64) begin
        check("ovr_second_valid", {31'd0, if_msb.P_VALID}, 32'd1);
        check("ovr_second_out_msb", if_msb.P_OUT, 32'hFFFF_FFFF);
        check("ovr_second_out_lsb", if_lsb.P_OUT, 32'hFFFF_FFFF);
        check("ovr_flag", {31'd0, if_msb.OVERRUN & if_lsb.OVERRUN}, 32'd1);
      end
      if (k == 65) begin
        check("ovr_flag_drop", {31'd0, if_msb.OVERRUN}, 32'd0);
        check("ovr_still_valid", {31'd0, if_msb.P_VALID}, 32'd1);
        p_ready = 1'b1;
      end
      if (k == 66) check("ovr_accepted", {31'd0, if_msb.P_VALID}, 32'd0);
      if (k < 32)      begin s_start = 1'b1; s_in = (k == 31); end
      else if (k < 64) begin s_start = 1'b1; s_in = 1'b1; end
      else             s_start = 1'b0;
    end
    check("ovr_pulse_count", ovr, 1);

    // Reset mid-frame: a partial word is discarded, the next frame starts clean.
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      drive_bit(1'($urandom));
      if (if_msb.P_VALID) pulses++;
    end
    @(negedge clk);
    if (if_msb.P_VALID) pulses++;
    rst = 1'b1; s_start = 1'b1; s_in = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, if_msb.BUSY | if_lsb.BUSY}, 32'd0);
    check("midrst_valid", {31'd0, if_msb.P_VALID | if_lsb.P_VALID}, 32'd0);
    rst = 1'b0; s_start = 1'b0;
    send_word(32'h8000_0000, -1, -1, 0, lat);
    check("midrst_spurious", pulses, 0);
    check("midrst_latency", lat, 32);
    check("midrst_out_msb", if_msb.P_OUT, 32'h8000_0000);
    check("midrst_out_lsb", if_lsb.P_OUT, 32'h0000_0001);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_start = ($urandom_range(0, 9) < 7);
      s_in    = 1'($urandom);
      p_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
